denorm_shift_16: RTL

- Pipelined right-shift denormalizer; inverse of the 16-bit leading-zero-detect/normalize path.
- Takes a left-normalized mantissa plus the shift count produced by the LZD (0..16, where 16 means an all-zero value) and restores the original fixed-point magnitude.
- Also emits a sticky bit for downstream rounding.
- Sits at the output of the AWGN datapath, e.g. after log/sqrt evaluation on normalized operands, converting back to fixed point before the noise sample is scaled.

---
 rtl/awgn_pkg.sv | 10 +
 rtl/denorm_stage.sv | 27 ++
 rtl/denorm_shift_16.sv | 93 +++++++++
 3 files changed

// File: rtl/awgn_pkg.sv
// Shared constants for the AWGN normalize/denormalize datapath.
// The LZD and the denormalizer both use LZD_ZERO_CODE to mark an all-zero operand.
package awgn_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int SHW_DEFAULT   = 5;

  localparam logic [4:0] LZD_ZERO_CODE = 5'd16;

endpackage

// File: rtl/denorm_stage.sv
// One conditional right-shift cell: shifts by SHIFT when sel is set and
// folds every discarded bit into the running sticky flag.
module denorm_stage
  import awgn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHIFT = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout
);

  // A shift of at least WIDTH discards the whole word.
  generate
    if (SHIFT >= WIDTH) begin : g_all
      assign dout = sel ? '0 : din;
      assign sout = sin | (sel & (|din));
    end else begin : g_part
      assign dout = sel ? (din >> SHIFT) : din;
      assign sout = sin | (sel & (|din[SHIFT-1:0]));
    end
  endgenerate

endmodule

// File: rtl/denorm_shift_16.sv
// Three-stage pipelined right-shift denormalizer with sticky output and
// bubble-collapsing valid/ready flow control.
module denorm_shift_16
  import awgn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHW   = SHW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [SHW-1:0]   in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  logic             v1, v2, v3;
  logic [WIDTH-1:0] d1, d2, d3;
  logic             s1, s2, s3;
  logic [2:0]       sh1;
  logic             sh2;
  logic             adv1, adv2, adv3;

  logic [WIDTH-1:0] c16_d, c8_d, c4_d, c2_d, c1_d;
  logic             c16_s, c8_s, c4_s, c2_s, c1_s;

  // A stage may load whenever it is empty or its successor is moving.
  assign adv3     = !v3 | out_ready;
  assign adv2     = !v2 | adv3;
  assign adv1     = !v1 | adv2;
  assign in_ready = adv1;

  denorm_stage #(.WIDTH(WIDTH), .SHIFT(16)) u_sh16 (
    .sel(in_shift[4]), .din(in_mant), .sin(1'b0), .dout(c16_d), .sout(c16_s));
  denorm_stage #(.WIDTH(WIDTH), .SHIFT(8)) u_sh8 (
    .sel(in_shift[3]), .din(c16_d), .sin(c16_s), .dout(c8_d), .sout(c8_s));
  denorm_stage #(.WIDTH(WIDTH), .SHIFT(4)) u_sh4 (
    .sel(sh1[2]), .din(d1), .sin(s1), .dout(c4_d), .sout(c4_s));
  denorm_stage #(.WIDTH(WIDTH), .SHIFT(2)) u_sh2 (
    .sel(sh1[1]), .din(c4_d), .sin(c4_s), .dout(c2_d), .sout(c2_s));
  denorm_stage #(.WIDTH(WIDTH), .SHIFT(1)) u_sh1 (
    .sel(sh2), .din(d2), .sin(s2), .dout(c1_d), .sout(c1_s));

  // Data registers only load when a real beat arrives, so held outputs stay put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      d1  <= '0;
      d2  <= '0;
      d3  <= '0;
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      sh1 <= '0;
      sh2 <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          d1  <= c8_d;
          s1  <= c8_s;
          sh1 <= in_shift[2:0];
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          d2  <= c2_d;
          s2  <= c2_s;
          sh2 <= sh1[0];
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          d3 <= c1_d;
          s3 <= c1_s;
        end
      end
    end
  end

  assign out_valid  = v3;
  assign out_data   = d3;
  assign out_sticky = s3;

endmodule
